// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC, IF/ID register, decode handshake.
// Optional misaligned-redirect trap enabled by IF_MISALIGN_TRAP_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] fetch_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } st_t;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  st_t             st;
  st_t             st_nx;
  ifid_t           ifid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] cnt;
  logic            fire;
  logic            load;
  logic            mis;
  logic            halt;

  assign pc4  = pc + 32'd4;
  assign tgt  = redirect_pc & ~32'h3;
  assign fire = id_valid & id_ready;
  assign load = fetch_en & (~id_valid | id_ready)
              & ~redirect_valid & ~halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= EMPTY;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    if (redirect_valid) st_nx = EMPTY;
    else if (load)      st_nx = FULL;
    else if (fire)      st_nx = EMPTY;
  end

  always_comb begin
    id_valid = (st == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      if (!mis) pc <= tgt;
    end else if (load) begin
      pc <= pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid <= '{pc: '0, inst: NOP, pc4: '0};
    end else if (load) begin
      ifid <= '{pc: pc, inst: imem_inst, pc4: pc4};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (fire) cnt <= cnt + 32'd1;
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic            trap_q;
  logic [XLEN-1:0] trap_pc_q;
  logic            halt_q;

  assign mis = redirect_valid & (|redirect_pc[1:0]);

  // Misaligned target parks fetch until an aligned redirect arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
      halt_q    <= 1'b0;
    end else begin
      trap_q <= mis;
      if (mis)            trap_pc_q <= redirect_pc;
      if (redirect_valid) halt_q    <= mis;
    end
  end

  assign halt          = halt_q;
  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
`else
  assign mis           = 1'b0;
  assign halt          = 1'b0;
  assign misalign_trap = 1'b0;
  assign trap_pc       = '0;
`endif

  assign imem_addr   = pc;
  assign id_pc       = ifid.pc;
  assign id_inst     = ifid.inst;
  assign id_pc_plus4 = ifid.pc4;
  assign fetch_count = cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
// Honours IF_MISALIGN_TRAP_EN for the misaligned-redirect step.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_trap;
  logic [31:0] trap_pc;
  logic [31:0] fetch_count;

  int total = 0;
  int fails = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_pc_plus4    (id_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_trap  (misalign_trap),
    .trap_pc        (trap_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h3000_0093;
      32'h0000_0004: rom = 32'h0140_9093;
      32'h0000_0008: rom = 32'h0430_0113;
      32'h0000_0020: rom = 32'h0200_0113;
      default:       rom = 32'h0010_0013 + a;
    endcase
  endfunction

  always_comb imem_inst = rom(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'h0);
    chk("rst_trap_pc", trap_pc, 32'h0);

    rst_n    = 1'b1;
    fetch_en = 1'b1;
    id_ready = 1'b1;
    tick();
    chk("t1_valid", {31'b0, id_valid}, 32'h1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_inst0", id_inst, 32'h3000_0093);
    chk("t1_pc4_0", id_pc_plus4, 32'h4);
    chk("t1_addr", imem_addr, 32'h4);
    tick();
    chk("t1_pc4", id_pc, 32'h4);
    chk("t1_inst4", id_inst, 32'h0140_9093);
    chk("t1_cnt1", fetch_count, 32'd1);
    tick();
    chk("t1_pc8", id_pc, 32'h8);
    chk("t1_inst8", id_inst, 32'h0430_0113);
    chk("t1_cnt2", fetch_count, 32'd2);

    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_pc", id_pc, 32'h8);
      chk("t2_hold_inst", id_inst, 32'h0430_0113);
      chk("t2_hold_addr", imem_addr, 32'hC);
      chk("t2_hold_cnt", fetch_count, 32'd2);
    end
    id_ready = 1'b1;
    tick();
    chk("t2_pcC", id_pc, 32'hC);
    chk("t2_instC", id_inst, 32'h0010_001F);
    chk("t2_cnt3", fetch_count, 32'd3);

    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    chk("t3_empty", {31'b0, id_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'h20);
    chk("t3_cnt", fetch_count, 32'd3);
    tick();
    chk("t3_valid", {31'b0, id_valid}, 32'h1);
    chk("t3_pc", id_pc, 32'h20);
    chk("t3_inst", id_inst, 32'h0200_0113);
    chk("t3_cnt2", fetch_count, 32'd3);

    id_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_pre_pc", id_pc, 32'h2C);
    chk("t4_pre_cnt", fetch_count, 32'd6);
    rst_n = 1'b0;
    #1;
    chk("t4_async_v", {31'b0, id_valid}, 32'h0);
    chk("t4_async_a", imem_addr, 32'h0);
    chk("t4_async_c", fetch_count, 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t4_pc", id_pc, 32'h0);
    chk("t4_valid", {31'b0, id_valid}, 32'h1);
    chk("t4_cnt", fetch_count, 32'h0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("t5_empty", {31'b0, id_valid}, 32'h0);
    chk("t5_cnt_fire", fetch_count, 32'd1);
    tick();
    chk("t5_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("t5_pc4_wrap", id_pc_plus4, 32'h0);
    chk("t5_inst_top", id_inst, 32'h0010_000F);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    tick();
    chk("t5_pc0", id_pc, 32'h0);
    chk("t5_pc4", id_pc_plus4, 32'h4);
    chk("t5_inst0", id_inst, 32'h3000_0093);
    chk("t5_cnt", fetch_count, 32'd2);

    fetch_en = 1'b0;
    tick();
    chk("fe_drain_v", {31'b0, id_valid}, 32'h0);
    chk("fe_drain_c", fetch_count, 32'd3);
    chk("fe_drain_a", imem_addr, 32'h4);
    tick();
    chk("fe_idle_v", {31'b0, id_valid}, 32'h0);
    chk("fe_idle_a", imem_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("fe_redir_a", imem_addr, 32'h40);
    tick();
    chk("fe_redir_v", {31'b0, id_valid}, 32'h0);
    fetch_en = 1'b1;
    tick();
    chk("fe_resume_pc", id_pc, 32'h40);
    chk("fe_resume_v", {31'b0, id_valid}, 32'h1);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    tick();
    redirect_valid = 1'b0;
    chk("t6_empty", {31'b0, id_valid}, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("t6_trap", {31'b0, misalign_trap}, 32'h1);
    chk("t6_trap_pc", trap_pc, 32'h22);
    chk("t6_pc_kept", imem_addr, 32'h44);
    tick();
    chk("t6_trap_end", {31'b0, misalign_trap}, 32'h0);
    chk("t6_trap_hold", trap_pc, 32'h22);
    chk("t6_parked", {31'b0, id_valid}, 32'h0);
    chk("t6_parked_a", imem_addr, 32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h44;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t6_resume_pc", id_pc, 32'h44);
    chk("t6_resume_v", {31'b0, id_valid}, 32'h1);
`else
    chk("t6_no_trap", {31'b0, misalign_trap}, 32'h0);
    chk("t6_trap_pc0", trap_pc, 32'h0);
    chk("t6_addr", imem_addr, 32'h20);
    tick();
    chk("t6_pc", id_pc, 32'h20);
    chk("t6_inst", id_inst, 32'h0200_0113);
    chk("t6_valid", {31'b0, id_valid}, 32'h1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
